// File: rtl/bp_nonsynth_cosim_commit_arbiter_if.sv
// Commit/step channel bundle for the cosim commit arbiter.
// slave: arbiter side (takes commits, drives step); master: cores + consumer.
interface bp_nonsynth_cosim_commit_arbiter_if #(
    parameter int num_core_p       = 4,
    parameter int commit_width_p   = 256,
    parameter int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
);
    logic [num_core_p-1:0]                commit_v_i;
    logic [num_core_p-1:0]                commit_instret_i;
    logic [num_core_p*commit_width_p-1:0] commit_data_i;
    logic [num_core_p-1:0]                commit_yumi_o;
    logic                                 step_v_o;
    logic [core_id_width_lp-1:0]          step_core_o;
    logic [commit_width_p-1:0]            step_data_o;
    logic                                 step_ready_i;

    modport slave (
        input  commit_v_i, commit_instret_i, commit_data_i, step_ready_i,
        output commit_yumi_o, step_v_o, step_core_o, step_data_o
    );

    modport master (
        output commit_v_i, commit_instret_i, commit_data_i, step_ready_i,
        input  commit_yumi_o, step_v_o, step_core_o, step_data_o
    );
endinterface

// File: rtl/bp_nonsynth_cosim_commit_arbiter.sv
// Round-robin arbiter sharing one cosim step channel among core commit streams,
// with per-core retire caps, finish flags and a no-progress watchdog.
// Ports: clk_i, reset_i (async, active-low), freeze_i, cosim_en_i, instr_cap_i,
//   cmt (commit valid/instret/data, yumi, step valid/core/data/ready),
//   finish_o, all_finish_o, timeout_o, done_o.
module bp_nonsynth_cosim_commit_arbiter #(
    parameter int num_core_p       = 4,
    parameter int commit_width_p   = 256,
    parameter int timeout_cycles_p = 100000,
    localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  freeze_i,
    input  logic                  cosim_en_i,
    input  logic [31:0]           instr_cap_i,
    bp_nonsynth_cosim_commit_arbiter_if.slave cmt,
    output logic [num_core_p-1:0] finish_o,
    output logic                  all_finish_o,
    output logic                  timeout_o,
    output logic                  done_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [31:0] TO = 32'(timeout_cycles_p);

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [core_id_width_lp-1:0] r_rr;
    logic [core_id_width_lp-1:0] w_win;
    logic [core_id_width_lp-1:0] w_j;
    logic                        w_found;
    logic [num_core_p-1:0]       w_yumi;
    logic                        w_slot_free;
    logic                        w_arb_en;
    logic                        w_grant;
    logic                        w_load;
    logic                        w_accept;
    logic [commit_width_p-1:0]   w_sel_data;

    logic                        r_step_v;
    logic [core_id_width_lp-1:0] r_step_core;
    logic [commit_width_p-1:0]   r_step_data;

    logic [31:0]                 r_cnt     [num_core_p];
    logic [31:0]                 w_cnt_nxt [num_core_p];
    logic [num_core_p-1:0]       r_finish;
    logic [31:0]                 r_wd;
    logic [31:0]                 w_wd_nxt;
    logic                        r_timeout;

    assign w_slot_free = ~r_step_v | cmt.step_ready_i;
    assign w_arb_en    = (r_state == RUN) & ~freeze_i & w_slot_free;

    // Priority search starting at the rr pointer, wrapping modulo num_core_p.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int k = 0; k < num_core_p; k++) begin
            w_j = core_id_width_lp'((int'(r_rr) + k) % num_core_p);
            if (!w_found && cmt.commit_v_i[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
    end

    assign w_grant = w_arb_en & w_found;

    always_comb begin
        w_yumi = '0;
        if (w_grant) begin
            w_yumi[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < num_core_p; i++) begin
            if (w_yumi[i]) begin
                w_sel_data = cmt.commit_data_i[i*commit_width_p +: commit_width_p];
            end
        end
    end

    // Records from cores already at their cap are consumed but not forwarded.
    assign w_load   = |(w_yumi & ~r_finish);
    assign w_accept = r_step_v & cmt.step_ready_i;

    always_comb begin
        for (int i = 0; i < num_core_p; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_yumi[i] && !r_finish[i] && cmt.commit_instret_i[i]
                && r_cnt[i] != 32'hFFFF_FFFF) begin
                w_cnt_nxt[i] = r_cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        w_wd_nxt = r_wd;
        if (r_state == RUN && !freeze_i) begin
            if (w_grant) begin
                w_wd_nxt = '0;
            end else if (r_wd < TO) begin
                w_wd_nxt = r_wd + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (cosim_en_i && !freeze_i) w_state_nxt = RUN;
            RUN:     if (all_finish_o || timeout_o) w_state_nxt = DRAIN;
            DRAIN:   if (!r_step_v) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= IDLE;
            r_rr        <= '0;
            r_step_v    <= 1'b0;
            r_step_core <= '0;
            r_step_data <= '0;
            r_finish    <= '0;
            r_wd        <= '0;
            r_timeout   <= 1'b0;
            for (int i = 0; i < num_core_p; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rr <= (w_win == core_id_width_lp'(num_core_p - 1))
                        ? '0 : w_win + 1'b1;
            end
            if (w_load) begin
                r_step_v    <= 1'b1;
                r_step_core <= w_win;
                r_step_data <= w_sel_data;
            end else if (w_accept) begin
                r_step_v <= 1'b0;
            end
            for (int i = 0; i < num_core_p; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (instr_cap_i != 32'd0 && w_cnt_nxt[i] == instr_cap_i) begin
                    r_finish[i] <= 1'b1;
                end
            end
            r_wd <= w_wd_nxt;
            if (w_wd_nxt >= TO) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign cmt.commit_yumi_o = w_yumi;
    assign cmt.step_v_o      = r_step_v;
    assign cmt.step_core_o   = r_step_core;
    assign cmt.step_data_o   = r_step_data;
    assign finish_o          = r_finish;
    assign all_finish_o      = &r_finish;
    assign timeout_o         = r_timeout;
    assign done_o            = (r_state == DONE);
endmodule
